// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of N_CH output/input channels with
// two-flop input synchronisers and masked, sticky change-detect interrupts.
// Register map per channel k: OUT at BASE+8k, IN at BASE+8k+4; then MASK and
// PEND (write-1-to-clear) at BASE+8*N_CH and BASE+8*N_CH+4.
module io_port_bank #(
  parameter int          N_CH  = 2,
  parameter int          WIDTH = 8,
  parameter logic [31:0] BASE  = 32'h0000_07E0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    we,
  output logic [31:0]             rdata,
  output logic                    hit,
  input  logic [N_CH*WIDTH-1:0]   in_ports,
  output logic [N_CH*WIDTH-1:0]   out_ports,
  output logic                    irq
);

  localparam int unsigned WIN_WORDS = 2 * N_CH + 2;

  typedef enum logic [1:0] {
    DISARMED0 = 2'd0,
    DISARMED1 = 2'd1,
    ARMED     = 2'd2
  } arm_state_e;

  arm_state_e              state_q, state_d;
  logic                    armed_s;

  logic [N_CH*WIDTH-1:0]   out_q, out_d;
  logic [N_CH*WIDTH-1:0]   sync1_q, sync1_d;
  logic [N_CH*WIDTH-1:0]   sync2_q, sync2_d;
  logic [N_CH*WIDTH-1:0]   last_q, last_d;
  logic [N_CH-1:0]         mask_q, mask_d;
  logic [N_CH-1:0]         pend_q, pend_d;
  logic [N_CH-1:0]         chg_s;

  logic [31:0]             off_s;
  logic [31:0]             word_s;
  logic [30:0]             idx_s;
  logic                    sel_hi_s;
  logic                    ctl_sel_s;
  logic                    hit_s;
  logic                    pend_wr_s;
  logic                    unused_s;

  // Address decode: offset from BASE, word index, channel index and odd/even word.
  always_comb begin
    off_s     = addr - BASE;
    word_s    = {2'b00, off_s[31:2]};
    idx_s     = word_s[31:1];
    sel_hi_s  = word_s[0];
    ctl_sel_s = (idx_s == 31'(N_CH));
    hit_s     = (off_s[1:0] == 2'b00) && (word_s < 32'(WIN_WORDS));
    pend_wr_s = we && hit_s && ctl_sel_s && sel_hi_s;
  end

  // Bits of the bus that the bank does not consume.
  assign unused_s = ^{wdata, off_s[1:0]};

  // Arm sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISARMED0;
    end else begin
      state_q <= state_d;
    end
  end

  // Arm sequencer next state: two fill cycles after reset, then armed for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED0: state_d = DISARMED1;
      DISARMED1: state_d = ARMED;
      ARMED:     state_d = ARMED;
      default:   state_d = DISARMED0;
    endcase
  end

  // Arm sequencer output decode.
  always_comb begin
    if (state_q == ARMED) begin
      armed_s = 1'b1;
    end else begin
      armed_s = 1'b0;
    end
  end

  // Synchroniser and change-detect history; while disarmed, last follows the
  // value entering sync2 so the post-reset fill never looks like a change.
  always_comb begin
    sync1_d = in_ports;
    sync2_d = sync1_q;
    if (armed_s) begin
      last_d = sync2_q;
    end else begin
      last_d = sync1_q;
    end
  end

  // Change detect and sticky pending bits; a new change wins over a clear.
  always_comb begin
    chg_s  = '0;
    pend_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      chg_s[k]  = armed_s && (sync2_q[k*WIDTH +: WIDTH] != last_q[k*WIDTH +: WIDTH]);
      pend_d[k] = chg_s[k] | (pend_q[k] & ~(pend_wr_s & wdata[k]));
    end
  end

  // Bus writes to OUT and MASK registers.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    for (int k = 0; k < N_CH; k++) begin
      if (we && hit_s && !sel_hi_s && (idx_s == 31'(k))) begin
        out_d[k*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
      end else begin
        out_d[k*WIDTH +: WIDTH] = out_q[k*WIDTH +: WIDTH];
      end
    end
    if (we && hit_s && ctl_sel_s && !sel_hi_s) begin
      mask_d = wdata[N_CH-1:0];
    end else begin
      mask_d = mask_q;
    end
  end

  // Combinational read mux, zero-extended, zero outside the window.
  always_comb begin
    rdata = 32'h0000_0000;
    if (hit_s) begin
      for (int k = 0; k < N_CH; k++) begin
        if (idx_s == 31'(k)) begin
          if (sel_hi_s) begin
            rdata[WIDTH-1:0] = sync2_q[k*WIDTH +: WIDTH];
          end else begin
            rdata[WIDTH-1:0] = out_q[k*WIDTH +: WIDTH];
          end
        end else begin
          rdata = rdata;
        end
      end
      if (ctl_sel_s) begin
        if (sel_hi_s) begin
          rdata[N_CH-1:0] = pend_q;
        end else begin
          rdata[N_CH-1:0] = mask_q;
        end
      end else begin
        rdata = rdata;
      end
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
    end else begin
      out_q   <= out_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
    end
  end

  assign hit       = hit_s;
  assign out_ports = out_q;
  assign irq       = |(pend_q & mask_q);

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank (N_CH=2, WIDTH=8, BASE=0x7E0).
module tb_io_port_bank;

  localparam logic [31:0] B      = 32'h0000_07E0;
  localparam logic [31:0] A_OUT0 = B;
  localparam logic [31:0] A_IN0  = B + 32'd4;
  localparam logic [31:0] A_OUT1 = B + 32'd8;
  localparam logic [31:0] A_IN1  = B + 32'd12;
  localparam logic [31:0] A_MASK = B + 32'd16;
  localparam logic [31:0] A_PEND = B + 32'd20;

  localparam int K_RD  = 0;
  localparam int K_HIT = 1;
  localparam int K_OUT = 2;
  localparam int K_IRQ = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, hit, irq;
  logic [15:0] in_ports, out_ports;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        obs_v = 1'b0;
  exp_t        m_e;
  logic [31:0] m_act;

  io_port_bank #(.N_CH(2), .WIDTH(8), .BASE(32'h0000_07E0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .hit(hit), .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: whenever an observation is presented, pop the expectation and compare.
  always @(negedge clk) begin
    if (obs_v) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: observation with no expectation");
      end else begin
        m_e = sb.pop_front();
        case (m_e.kind)
          K_RD:    m_act = rdata;
          K_HIT:   m_act = {31'd0, hit};
          K_OUT:   m_act = {16'd0, out_ports};
          default: m_act = {31'd0, irq};
        endcase
        if (m_act !== m_e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
        end
      end
    end
  end

  // One observation per cycle: starts just after a rising edge, ends just after the next.
  task automatic chk(input int kind, input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    we   = 1'b0;
    sb.push_back('{kind, exp, name});
    obs_v = 1'b1;
    @(negedge clk);
    #1 obs_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    addr = 32'd0; wdata = 32'd0; we = 1'b0;
    in_ports = 16'hA55A;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset release with nonzero inputs.
    chk(K_OUT, 32'd0, 32'h0000_0000, "reset_out");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "reset_irq");
    chk(K_RD, A_IN0, 32'h0000_005A, "in0_sync");
    chk(K_RD, A_IN1, 32'h0000_00A5, "in1_sync");
    chk(K_HIT, A_PEND, 32'h0000_0001, "hit_pend");
    for (int i = 0; i < 8; i++) chk(K_RD, A_PEND, 32'h0000_0000, "pend_quiet");
    chk(K_RD, A_MASK, 32'h0000_0000, "reset_mask");

    // OUT writes.
    wr(A_OUT0, 32'h1234_56C3);
    chk(K_OUT, 32'd0, 32'h0000_00C3, "out0_store");
    wr(A_IN0, 32'hFFFF_FFFF);
    chk(K_OUT, 32'd0, 32'h0000_00C3, "in_write_ignored");
    chk(K_RD, A_OUT0, 32'h0000_00C3, "out0_read");
    chk(K_RD, A_IN0, 32'h0000_005A, "in0_after_write");

    // Masked change on channel 1, then write-1-to-clear.
    wr(A_MASK, 32'h0000_0002);
    in_ports = 16'hA45A;
    chk(K_RD, A_PEND, 32'h0000_0000, "ch1_e1");
    chk(K_RD, A_PEND, 32'h0000_0000, "ch1_e2");
    chk(K_RD, A_IN1, 32'h0000_00A4, "in1_new");
    chk(K_RD, A_PEND, 32'h0000_0002, "ch1_pend");
    chk(K_IRQ, 32'd0, 32'h0000_0001, "ch1_irq");
    wr(A_PEND, 32'h0000_0002);
    chk(K_RD, A_PEND, 32'h0000_0000, "ch1_cleared");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "ch1_irq_cleared");

    // Unmasked change on channel 0, then mask it in.
    in_ports = 16'hA45B;
    chk(K_IRQ, 32'd0, 32'h0000_0000, "ch0_irq_e1");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "ch0_irq_e2");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "ch0_irq_e3");
    chk(K_RD, A_PEND, 32'h0000_0001, "ch0_pend_masked");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "ch0_irq_masked");
    wr(A_MASK, 32'h0000_0001);
    chk(K_IRQ, 32'd0, 32'h0000_0001, "ch0_irq_unmasked");

    // Clear collides with a new detection: set wins.
    in_ports = 16'hA45C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr(A_PEND, 32'h0000_0001);
    chk(K_RD, A_PEND, 32'h0000_0001, "set_beats_clear");

    // Out-of-window and unaligned accesses.
    chk(K_HIT, B + 32'd24, 32'h0000_0000, "hit_past_end");
    chk(K_RD, B + 32'd24, 32'h0000_0000, "rdata_past_end");
    chk(K_HIT, B + 32'd2, 32'h0000_0000, "hit_unaligned");
    chk(K_RD, B + 32'd2, 32'h0000_0000, "rdata_unaligned");
    wr(B + 32'd24, 32'hFFFF_FFFF);
    wr(B + 32'd2, 32'hFFFF_FFFF);
    wr(B + 32'd18, 32'hFFFF_FFFF);
    chk(K_RD, A_MASK, 32'h0000_0001, "mask_untouched");
    chk(K_RD, A_OUT0, 32'h0000_00C3, "out0_untouched");
    chk(K_RD, A_PEND, 32'h0000_0001, "pend_untouched");

    // Full state, then reset mid-run.
    wr(A_OUT0, 32'h0000_00FF);
    wr(A_OUT1, 32'hFFFF_FFFF);
    wr(A_MASK, 32'h0000_0003);
    in_ports = 16'hA55C;
    chk(K_OUT, 32'd0, 32'h0000_FFFF, "out_full");
    chk(K_IRQ, 32'd0, 32'h0000_0001, "irq_full");
    chk(K_RD, A_PEND, 32'h0000_0001, "pend_before_ch1");
    chk(K_RD, A_PEND, 32'h0000_0003, "pend_both");
    reset = 1'b1;
    @(posedge clk); #1;
    chk(K_OUT, 32'd0, 32'h0000_0000, "midreset_out");
    chk(K_IRQ, 32'd0, 32'h0000_0000, "midreset_irq");
    chk(K_RD, A_PEND, 32'h0000_0000, "midreset_pend");
    chk(K_RD, A_MASK, 32'h0000_0000, "midreset_mask");
    chk(K_RD, A_IN1, 32'h0000_0000, "midreset_in1");
    reset = 1'b0;

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised, memory-mapped I/O port bank for the single-cycle ARM core. It replaces the single fixed 8-bit IN/OUT port pair with N independent channels. Each channel has a registered output, a two-flop-synchronised input, and change-detect interrupt logic with mask and write-1-to-clear pending bits. It sits beside data memory on the data bus: `hit` steers the system read mux, and `irq` feeds the core's interrupt pulse logic.

## Interface
- N_CH, 2: number of channels, 1..16
- WIDTH, 8: bits per channel, 1..32
- BASE, 32'h7E0: word-aligned byte address of channel 0 OUT register; window spans BASE .. BASE+8*N_CH+4

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  byte address from ALUResult
- wdata  in  32  store data
- we  in  1  store strobe (MemWrite)
- rdata  out  32  combinational read data, zero-extended
- hit  out  1  combinational; 1 when addr is a mapped register in the window
- in_ports  in  N_CH*WIDTH  asynchronous external inputs, channel k at [k*WIDTH +: WIDTH]
- out_ports  out  N_CH*WIDTH  registered external outputs, same packing
- irq  out  1  combinational: |(pend & mask)

## Operation
- Register map, offset from BASE, k = 0..N_CH-1:
  - 8k: OUT[k], read/write; a write stores wdata[WIDTH-1:0] and ignores upper bits.
  - 8k+4: IN[k], read-only; returns sync2[k]; writes are ignored.
  - 8*N_CH: MASK, read/write, bits [N_CH-1:0].
  - 8*N_CH+4: PEND, read; a write of 1 clears the corresponding bit.
- `hit` = 1 only for these exact word addresses with addr[1:0]==0. Otherwise `hit`=0 and rdata=0.
- Writes occur only when we & hit. Unmapped or unaligned addresses have no effect.
- Per-channel input path: in_ports → sync1 → sync2 → last. Each stage is a WIDTH-bit register updated every cycle.
- Change detect: chg[k] = armed & (sync2[k] != last[k]). Any bit change counts.
- PEND[k] next value = chg[k] | (PEND[k] & ~(pend_wr & wdata[k])). A set from chg wins over a simultaneous clear.
- Arm sequencer, 2-bit counter ARM_CNT, states DISARMED0 → DISARMED1 → ARMED:
  - Reset forces DISARMED0.
  - The counter advances one state per cycle; ARMED holds until the next reset.
  - `armed` = (state==ARMED). This suppresses spurious pending bits while the synchroniser fills after reset.
- MASK changes do not alter PEND. irq reflects the new mask combinationally on the next cycle's register value.

## Timing
- Reset values (after the reset edge): out_ports=0, MASK=0, PEND=0, sync1=sync2=last=0, state=DISARMED0, irq=0.
  - rdata and hit stay combinational during reset.
- OUT write: store at edge E; out_ports shows the new value after E, a 1-cycle store-to-pin latency.
- Input latency: an in_ports change stable before edge E1 reaches:
  - sync1 after E1;
  - sync2 after E2, readable via IN[k] in the cycle after E2;
  - PEND[k] set at E3, with irq high after E3 if MASK[k]=1.
- Changes before ARMED:
  - last tracks sync2 every cycle, so a nonzero input at reset release never sets PEND.
  - First possible set is 3 edges after reset deassert.
- Input toggling back within one cycle still produces a pending set for each sync2 transition. Pending bits are sticky (no count).
- Reset asserted mid-operation: all state returns to reset values at that edge, and pending or in-flight changes are discarded.
- A PEND read and a clear in the same instruction are not possible (single-cycle core). A read returns the pre-edge value.

## Test plan
- Reset release with in_ports=16'hA55A (N_CH=2, WIDTH=8) → PEND stays 0 for 10 cycles; IN[0] reads 0x5A and IN[1] reads 0xA5 from the 3rd cycle after reset.
- Store 0x1234_56C3 to BASE → out_ports[7:0]=0xC3 one edge later, and channel 1 is unchanged. A store to BASE+4 leaves out_ports unchanged.
- MASK=2'b10. Toggle in_ports[15:8] from 0xA5 to 0xA4 → PEND=2'b10 exactly 3 edges later, irq=1. Write PEND=2'b10 → PEND=0, irq=0 next cycle.
- Channel 0 changes while MASK[0]=0 → PEND[0]=1, irq stays 0. Then write MASK=2'b01 → irq=1 in the next cycle.
- Clear PEND[0] in the same edge that a new channel-0 change is detected → PEND[0] remains 1.
- Access addr=BASE+8*N_CH+8 and addr=BASE+2 → hit=0, rdata=0, no register changes. Assert reset mid-run with PEND=2'b11 and out=0xFFFF → all outputs return to 0 after the edge.
